// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line, write-through/no-write-allocate data cache in front of a handshaked RAM.
// Load hits return in the same cycle; misses and stores stall until mem_ack. Optional counters: DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            byte_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int IDX = $clog2(SETS);
  localparam int TW  = ADDR_WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                r_state, w_next;
  logic [SETS-1:0]       r_valid;
  logic [TW-1:0]         r_tag  [SETS];
  logic [DATA_WIDTH-1:0] r_data [SETS];

  logic                  r_mem_req, r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_be;

  logic [IDX-1:0]        w_idx, w_lidx;
  logic [TW-1:0]         w_tag, w_ltag;
  logic                  w_hit, w_lhit, w_fill_start, w_store_start, w_done, w_rd_hit;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_unused;

  assign w_idx    = addr[IDX+1:2];
  assign w_tag    = addr[ADDR_WIDTH-1:IDX+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // The registered memory address doubles as the latched request address.
  assign w_lidx   = r_mem_addr[IDX+1:2];
  assign w_ltag   = r_mem_addr[ADDR_WIDTH-1:IDX+2];
  assign w_lhit   = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
  assign w_done   = (r_state != IDLE) && mem_ack;
  assign w_unused = ^addr[1:0];

  always_comb begin
    w_merged = r_data[w_lidx];
    for (int b = 0; b < 4; b++)
      if (r_mem_be[b]) w_merged[8*b +: 8] = r_mem_wdata[8*b +: 8];
  end

  always_comb begin
    w_next        = r_state;
    stall         = 1'b0;
    rdata         = '0;
    w_fill_start  = 1'b0;
    w_store_start = 1'b0;
    w_rd_hit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_write) begin
          stall         = 1'b1;
          w_store_start = 1'b1;
          w_next        = WRITE;
        end else if (read_en) begin
          if (w_hit) begin
            rdata    = r_data[w_idx];
            w_rd_hit = 1'b1;
          end else begin
            stall        = 1'b1;
            w_fill_start = 1'b1;
            w_next       = FILL;
          end
        end
      end
      FILL, WRITE: begin
        stall = 1'b1;
        if (mem_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Outputs read as idle while reset is held, whatever the core presents.
    if (!rst_n) begin
      stall = 1'b0;
      rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_state <= w_next;
      if (w_fill_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        r_mem_wdata <= '0;
        r_mem_be    <= '0;
      end else if (w_store_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        r_mem_wdata <= wdata;
        r_mem_be    <= byte_en;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
      if (r_state == FILL && mem_ack) r_valid[w_lidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == FILL && mem_ack) begin
      r_data[w_lidx] <= mem_rdata;
      r_tag[w_lidx]  <= w_ltag;
    end else if (r_state == WRITE && mem_ack && w_lhit) begin
      r_data[w_lidx] <= w_merged;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic        r_after_fill;

  // The load replayed right after a fill is not counted as a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_after_fill <= 1'b0;
    end else begin
      r_after_fill <= (r_state == FILL) && mem_ack;
      if (w_fill_start && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_rd_hit && !r_after_fill && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a latency-programmable memory responder plus per-scenario checking tasks.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_en = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        stall, mem_req, mem_we;
  logic        r_ack = 1'b0, r_stale = 1'b0;
  int          mem_lat = 1;
  logic [31:0] mem_val = '0;
  int          req_cycles = 0;
  logic        prev_req = 1'b0;
  int          n_req = 0;
  logic        last_we = 1'b0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_be = '0;
  int          nvec = 0, nerr = 0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(r_ack | r_stale), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory: acks in the mem_lat-th cycle of a request, for one cycle.
  always @(negedge clk) begin
    if (mem_req && !r_ack) begin
      req_cycles++;
      if (req_cycles == mem_lat) begin
        r_ack     = 1'b1;
        mem_rdata = mem_val;
      end
    end else begin
      r_ack      = 1'b0;
      req_cycles = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      n_req++;
      last_we    = mem_we;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      last_be    = mem_be;
    end
    prev_req = mem_req;
  end

  task automatic wait_stall(output int n);
    n = 0;
    while (stall === 1'b1 && n < 50) begin
      n++;
      @(negedge clk); #1;
    end
    if (n >= 50) begin
      $display("FAIL stall_timeout: stall still %b after %0d cycles, want 0", stall, n);
      nerr++; nvec++;
    end
  endtask

  task automatic test_reset;
    read_en = 1'b1; addr = 32'h40;
    @(negedge clk); #1;
    if (stall !== 1'b0)     begin $display("FAIL rst_stall: got %b want 0", stall); nerr++; end nvec++;
    if (mem_req !== 1'b0)   begin $display("FAIL rst_req: got %b want 0", mem_req); nerr++; end nvec++;
    if (mem_we !== 1'b0)    begin $display("FAIL rst_we: got %b want 0", mem_we); nerr++; end nvec++;
    if (mem_addr !== 32'h0) begin $display("FAIL rst_addr: got %h want 0", mem_addr); nerr++; end nvec++;
    if (mem_wdata !== 32'h0) begin $display("FAIL rst_wdata: got %h want 0", mem_wdata); nerr++; end nvec++;
    if (mem_be !== 4'h0)    begin $display("FAIL rst_be: got %h want 0", mem_be); nerr++; end nvec++;
    if (rdata !== 32'h0)    begin $display("FAIL rst_rdata: got %h want 0", rdata); nerr++; end nvec++;
    read_en = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    if (stall !== 1'b0 || rdata !== 32'h0) begin
      $display("FAIL idle_out: stall %b rdata %h want 0/0", stall, rdata); nerr++;
    end nvec++;
  endtask

  task automatic test_load_miss;
    int n, r0;
    @(negedge clk);
    mem_lat = 3; mem_val = 32'hDEADBEEF; r0 = n_req;
    read_en = 1'b1; addr = 32'h40; #1;
    wait_stall(n);
    if (n != 4) begin $display("FAIL miss_stall_cycles: got %0d want 4", n); nerr++; end nvec++;
    if (rdata !== 32'hDEADBEEF) begin $display("FAIL miss_rdata: got %h want deadbeef", rdata); nerr++; end nvec++;
    if (n_req != r0 + 1 || last_we !== 1'b0 || last_addr !== 32'h40) begin
      $display("FAIL miss_req: reqs %0d we %b addr %h want 1/0/00000040", n_req - r0, last_we, last_addr); nerr++;
    end nvec++;
    @(negedge clk); addr = 32'h42; #1;
    if (stall !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      $display("FAIL rehit: stall %b req %b rdata %h want 0/0/deadbeef", stall, mem_req, rdata); nerr++;
    end nvec++;
    read_en = 1'b0;
  endtask

  task automatic test_store_hit;
    int n, r0;
    @(negedge clk);
    mem_lat = 2; r0 = n_req;
    mem_write = 1'b1; addr = 32'h40; wdata = 32'h000000AA; byte_en = 4'b0001; #1;
    if (stall !== 1'b1) begin $display("FAIL st_stall0: got %b want 1", stall); nerr++; end nvec++;
    @(negedge clk);
    mem_write = 1'b0; addr = 32'h80; wdata = 32'hFFFFFFFF; byte_en = 4'b1111; #1;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      $display("FAIL st_req: req %b we %b want 1/1", mem_req, mem_we); nerr++;
    end nvec++;
    wait_stall(n);
    if (n != 2) begin $display("FAIL st_write_cycles: got %0d want 2", n); nerr++; end nvec++;
    if (n_req != r0 + 1 || last_addr !== 32'h40 || last_be !== 4'b0001 || last_wdata !== 32'hAA) begin
      $display("FAIL st_latched: reqs %0d addr %h be %b wdata %h want 1/00000040/0001/000000aa",
               n_req - r0, last_addr, last_be, last_wdata); nerr++;
    end nvec++;
    @(negedge clk); r0 = n_req; read_en = 1'b1; addr = 32'h40; #1;
    if (stall !== 1'b0 || rdata !== 32'hDEADBEAA) begin
      $display("FAIL st_merge: stall %b rdata %h want 0/deadbeaa", stall, rdata); nerr++;
    end nvec++;
    @(negedge clk); read_en = 1'b0;
    if (n_req != r0) begin $display("FAIL st_merge_nomem: got %0d reqs want 0", n_req - r0); nerr++; end nvec++;
  endtask

  task automatic test_zero_be;
    int n, r0;
    @(negedge clk);
    mem_lat = 1; r0 = n_req;
    mem_write = 1'b1; addr = 32'h40; wdata = 32'hFFFFFFFF; byte_en = 4'b0000;
    @(negedge clk); mem_write = 1'b0; #1;
    wait_stall(n);
    if (n_req != r0 + 1 || last_be !== 4'b0000 || last_we !== 1'b1) begin
      $display("FAIL zbe_req: reqs %0d be %b we %b want 1/0000/1", n_req - r0, last_be, last_we); nerr++;
    end nvec++;
    @(negedge clk); read_en = 1'b1; addr = 32'h40; #1;
    if (stall !== 1'b0 || rdata !== 32'hDEADBEAA) begin
      $display("FAIL zbe_data: stall %b rdata %h want 0/deadbeaa", stall, rdata); nerr++;
    end nvec++;
    read_en = 1'b0;
  endtask

  task automatic test_store_miss;
    int n;
    @(negedge clk);
    mem_lat = 1;
    mem_write = 1'b1; addr = 32'h80; wdata = 32'h12345678; byte_en = 4'b1111;
    @(negedge clk); mem_write = 1'b0; #1;
    wait_stall(n);
    if (last_we !== 1'b1 || last_addr !== 32'h80) begin
      $display("FAIL sm_write: we %b addr %h want 1/00000080", last_we, last_addr); nerr++;
    end nvec++;
    @(negedge clk); mem_lat = 2; mem_val = 32'h12345678;
    read_en = 1'b1; addr = 32'h80; #1;
    if (stall !== 1'b1) begin $display("FAIL sm_noalloc: stall %b want 1", stall); nerr++; end nvec++;
    @(negedge clk); #1;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h80) begin
      $display("FAIL sm_fill: req %b we %b addr %h want 1/0/00000080", mem_req, mem_we, mem_addr); nerr++;
    end nvec++;
    wait_stall(n);
    if (rdata !== 32'h12345678) begin $display("FAIL sm_rdata: got %h want 12345678", rdata); nerr++; end nvec++;
    read_en = 1'b0;
  endtask

  task automatic test_alias;
    int n;
    logic [31:0] seq_addr [3];
    logic [31:0] seq_val  [3];
    seq_addr = '{32'h40, 32'h440, 32'h40};
    seq_val  = '{32'h11111111, 32'h22222222, 32'h33333333};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_lat = 1; mem_val = seq_val[i];
      read_en = 1'b1; addr = seq_addr[i]; #1;
      wait_stall(n);
      if (n != 2) begin $display("FAIL alias_miss%0d: stall cycles %0d want 2", i, n); nerr++; end nvec++;
      if (rdata !== seq_val[i]) begin $display("FAIL alias_data%0d: got %h want %h", i, rdata, seq_val[i]); nerr++; end nvec++;
      read_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_fill;
    int n;
    @(negedge clk);
    mem_lat = 5; read_en = 1'b1; addr = 32'h100;
    @(negedge clk); @(negedge clk); #1;
    if (mem_req !== 1'b1 || stall !== 1'b1) begin
      $display("FAIL mid_fill: req %b stall %b want 1/1", mem_req, stall); nerr++;
    end nvec++;
    rst_n = 1'b0; #1;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL rst_drop: req %b stall %b want 0/0", mem_req, stall); nerr++;
    end nvec++;
    @(negedge clk); rst_n = 1'b1; read_en = 1'b0; r_stale = 1'b1; #1;
    if (mem_req !== 1'b0) begin $display("FAIL stale_req0: got %b want 0", mem_req); nerr++; end nvec++;
    @(negedge clk); r_stale = 1'b0; #1;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL stale_ack: req %b stall %b want 0/0", mem_req, stall); nerr++;
    end nvec++;
    @(negedge clk); mem_lat = 2; mem_val = 32'hA5A5A5A5;
    read_en = 1'b1; addr = 32'h40; #1;
    if (stall !== 1'b1) begin $display("FAIL rst_inval: stall %b want 1", stall); nerr++; end nvec++;
    wait_stall(n);
    if (n != 3 || rdata !== 32'hA5A5A5A5) begin
      $display("FAIL rst_refill: cycles %0d rdata %h want 3/a5a5a5a5", n, rdata); nerr++;
    end nvec++;
    read_en = 1'b0;
  endtask

  task automatic test_read_and_write;
    int n, r0;
    @(negedge clk);
    mem_lat = 1; r0 = n_req;
    read_en = 1'b1; mem_write = 1'b1; addr = 32'h40; wdata = 32'h00000055; byte_en = 4'b0011; #1;
    if (stall !== 1'b1 || rdata !== 32'h0) begin
      $display("FAIL rw_idle: stall %b rdata %h want 1/0", stall, rdata); nerr++;
    end nvec++;
    @(negedge clk); read_en = 1'b0; mem_write = 1'b0; #1;
    wait_stall(n);
    if (n_req != r0 + 1 || last_we !== 1'b1) begin
      $display("FAIL rw_store: reqs %0d we %b want 1/1", n_req - r0, last_we); nerr++;
    end nvec++;
    @(negedge clk); read_en = 1'b1; addr = 32'h40; #1;
    if (stall !== 1'b0 || rdata !== 32'hA5A50055) begin
      $display("FAIL rw_merge: stall %b rdata %h want 0/a5a50055", stall, rdata); nerr++;
    end nvec++;
    read_en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_load_miss;
    test_store_hit;
    test_zero_be;
    test_store_miss;
    test_alias;
    test_reset_mid_fill;
    test_read_and_write;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Data-side responder for the control signals produced by the main decoder: consumes read_en (loads) and mem_write (stores) plus the ALU-computed address.
- Returns load data and a stall to the core.
- Direct-mapped, one word per line, write-through, no-write-allocate cache in front of a handshaked data memory.
- Sits between the datapath's memory stage and the data RAM.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes).
- SETS, 16, number of lines; power of 2, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read_en  in  1  load request from decoder.
- mem_write  in  1  store request from decoder.
- addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- wdata  in  32  store data.
- byte_en  in  4  store byte lanes; bit i selects wdata[8i+7:8i].
- rdata  out  32  load data; valid when read_en=1 and stall=0.
- stall  out  1  core must hold PC and memory-stage inputs.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1=write, 0=read; stable while mem_req=1.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address (bits [1:0]=0).
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_ack  in  1  one-cycle completion; mem_rdata valid that cycle for reads.
- mem_rdata  in  32  memory read data.

Behaviour:
- Address split: index = addr[IDX+1:2] with IDX=log2(SETS); tag = addr[ADDR_WIDTH-1:IDX+2].
- Storage per line: valid bit, tag, 32-bit data.
- Reset (async, rst_n=0):
  - all valid bits cleared; state=IDLE.
  - stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, rdata=0.
  - mem_req drops immediately even mid-transaction.
  - A stale mem_ack after reset is ignored.
- States: IDLE, FILL, WRITE.
- IDLE, no request: stall=0, mem_req=0, rdata=0.
- IDLE, read_en=1 and hit (valid and tag match):
  - rdata = line data combinationally, stall=0.
  - Zero added latency; no state change.
- IDLE, read_en=1 and miss:
  - stall=1 combinationally in the same cycle.
  - Latch word address; next state FILL.
- IDLE, mem_write=1:
  - stall=1 combinationally.
  - Latch address, wdata, byte_en; next state WRITE.
- Simultaneous read_en and mem_write: treated as a store; read_en ignored.
- FILL:
  - mem_req=1, mem_we=0, mem_addr=latched address, stall=1.
  - On mem_ack: write mem_rdata into the line, set valid, write tag; next state IDLE.
  - The replayed load then hits in IDLE, so total load-miss latency = memory latency + 1 cycle.
- WRITE:
  - mem_req=1, mem_we=1, mem_wdata/mem_be = latched values, stall=1.
  - On mem_ack, if the latched address hits: merge wdata into the line under byte_en (lanes with byte_en=0 keep old bytes). On a miss the line is untouched (no allocate).
  - Next state IDLE; stall=0 in that IDLE cycle only if no new miss or store is presented.
- mem_req, mem_we, mem_addr, mem_wdata, mem_be are registered, changing only on state entry; they are held stable until mem_ack.
- mem_ack while mem_req=0 is ignored.
- Aliasing: two addresses with the same index evict each other on fill. The tag compare uses the full upper address.
- byte_en=4'b0000 store: still performs the memory transaction; cache data unchanged.
- Inputs addr, wdata, byte_en may change during stall; only the latched copies are used.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0, saturating at 32'hFFFFFFFF.
  - miss_cnt increments on each IDLE→FILL transition.
  - hit_cnt increments on each IDLE read hit, excluding the replay cycle immediately following a FILL.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- After reset, read_en=1, addr=0x40, mem returns 0xDEADBEEF with ack after 3 cycles -> stall=1 for exactly 4 cycles, then rdata=0xDEADBEEF with stall=0; a repeat read of 0x40 has stall=0 and mem_req stays 0.
- Line at 0x40 holds 0xDEADBEEF; store wdata=0x000000AA, byte_en=0001 to 0x40 -> mem_req/mem_we=1, mem_be=0001, mem_addr=0x40; after ack, a read of 0x40 returns 0xDEADBEAA with no memory access.
- Store to uncached 0x80 -> memory write issued; a subsequent read of 0x80 misses (mem_req=1, mem_we=0).
- SETS=16: fill 0x40, then read 0x440 (same index) -> miss and fill; a re-read of 0x40 misses again.
- rst_n=0 asserted during FILL with mem_req=1 -> mem_req and stall drop immediately; after release, a read of the previously cached address misses.
- read_en=1 and mem_write=1 together to 0x40 -> store path only (mem_we=1), no read fill.
